// File: rtl/riscv_mdu_if.sv
// Request/response bundle between the register-file read/write ports and the
// RV32M multiply/divide unit.
interface riscv_mdu_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  // start is a request, taken only when busy=0 and kill=0; done is a one-cycle
  // pulse qualifying result/rd_out, which then hold until the next completion.
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [REGW-1:0] rd_in;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [REGW-1:0] rd_out;

  modport master (
    output start, funct3, a, b, rd_in, kill,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, a, b, rd_in, kill,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/riscv_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// 32 iterations plus one sign-correction cycle per operation.
module riscv_mdu #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  riscv_mdu_if.slave  mdu,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [4:0]      cnt_q;
  logic [2:0]      op_q;
  logic [REGW-1:0] rd_q;
  logic            neg_a_q, neg_b_q, b_zero_q;
  logic [XLEN-1:0] acc_q, lo_q, opb_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [REGW-1:0] rd_out_q;

  logic            sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_shift;
  logic            div_ok;
  logic [XLEN-1:0] acc_d, lo_d;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, res_d;

  // Operand sign handling: MULH a,b; MULHSU a only; DIV/REM a,b.
  always_comb begin
    sgn_a = (mdu.funct3 == 3'd1) || (mdu.funct3 == 3'd2) ||
            (mdu.funct3 == 3'd4) || (mdu.funct3 == 3'd6);
    sgn_b = (mdu.funct3 == 3'd1) || (mdu.funct3 == 3'd4) ||
            (mdu.funct3 == 3'd6);
    a_neg = sgn_a && mdu.a[XLEN-1];
    b_neg = sgn_b && mdu.b[XLEN-1];
    a_mag = a_neg ? -mdu.a : mdu.a;
    b_mag = b_neg ? -mdu.b : mdu.b;
  end

  // One iteration: multiply keeps {acc,lo} as the product shifting right;
  // divide shifts the dividend out of lo into acc and quotient bits into lo.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_ok    = (div_shift >= {1'b0, opb_q});
    if (op_q[2]) begin
      acc_d = div_ok ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], div_ok};
    end else begin
      acc_d = mul_sum[XLEN:1];
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign correction and result selection, consumed in DONE.
  always_comb begin
    prod     = {acc_q, lo_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    quot_fix = b_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -lo_q : lo_q);
    rem_fix  = neg_a_q ? -acc_q : acc_q;
    case (op_q)
      3'd0:                res_d = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    res_d = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          res_d = quot_fix;
      default:             res_d = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mdu.start && !mdu.kill) begin
            op_q     <= mdu.funct3;
            rd_q     <= mdu.rd_in;
            neg_a_q  <= a_neg;
            neg_b_q  <= b_neg;
            b_zero_q <= (mdu.b == '0);
            acc_q    <= '0;
            lo_q     <= a_mag;
            opb_q    <= b_mag;
            cnt_q    <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (mdu.kill) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!mdu.kill) begin
            result_q <= res_d;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mdu.busy    = (state_q != S_IDLE);
  assign mdu.done    = done_q;
  assign mdu.result  = result_q;
  assign mdu.rd_out  = rd_out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// Directed bench for riscv_mdu: vector table for arithmetic, hand-written
// sequences for kill, start-while-busy, back-to-back and asynchronous reset.
module tb_riscv_mdu;

  logic       clk;
  logic       reset_n;
  logic [1:0] dbg_state;
  int         tests;
  int         fails;
  int         edge_cnt;

  riscv_mdu_if #(.XLEN(32), .REGW(5)) mdu_if ();

  riscv_mdu dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mdu         (mdu_if),
    .dbg_state_o (dbg_state)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op and wait for done; lat is the edge count after acceptance.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                       output int lat, output int busy_cnt, output int done_edge);
    bit seen;
    @(negedge clk);
    mdu_if.start  = 1'b1;
    mdu_if.funct3 = f;
    mdu_if.a      = a;
    mdu_if.b      = b;
    mdu_if.rd_in  = rd;
    @(posedge clk);
    #1;
    mdu_if.start = 1'b0;
    busy_cnt  = mdu_if.busy ? 1 : 0;
    lat       = -1;
    done_edge = -1;
    res       = '0;
    rdo       = '0;
    seen      = 1'b0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (mdu_if.done) begin
        seen      = 1'b1;
        lat       = i;
        done_edge = edge_cnt;
        res       = mdu_if.result;
        rdo       = mdu_if.rd_out;
      end else if (mdu_if.busy) begin
        busy_cnt++;
      end
    end
  endtask

  logic [31:0] res, res2;
  logic [4:0]  rdo, rdo2;
  int          lat, bcnt, de1, de2;
  bit          done_seen;

  initial begin
    tests = 0;
    fails = 0;
    vecs[0]  = '{3'd0, 32'd7,        32'd6,        5'd5,  32'd42};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        5'd11, 32'd14};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        5'd12, 32'd2};
    vecs[8]  = '{3'd4, 32'd123,      32'd0,        5'd13, 32'hFFFFFFFF};
    vecs[9]  = '{3'd6, 32'd123,      32'd0,        5'd14, 32'd123};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h00000000};
    vecs[12] = '{3'd5, 32'd55,       32'd0,        5'd17, 32'hFFFFFFFF};
    vecs[13] = '{3'd7, 32'hDEADBEEF, 32'd0,        5'd18, 32'hDEADBEEF};
    vecs[14] = '{3'd0, 32'hFFFFFFFD, 32'd5,        5'd19, 32'hFFFFFFF1};
    vecs[15] = '{3'd1, 32'h80000000, 32'h80000000, 5'd20, 32'h40000000};
    vecs[16] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000};
    vecs[17] = '{3'd4, 32'd7,        32'hFFFFFFFE, 5'd22, 32'hFFFFFFFD};
    vecs[18] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd0,  32'd1};
    vecs[19] = '{3'd0, 32'd5,        32'd5,        5'd9,  32'd25};

    mdu_if.start  = 1'b0;
    mdu_if.funct3 = '0;
    mdu_if.a      = '0;
    mdu_if.b      = '0;
    mdu_if.rd_in  = '0;
    mdu_if.kill   = 1'b0;
    reset_n       = 1'b0;
    #22;
    check("reset_busy",   {31'd0, mdu_if.busy}, 32'd0);
    check("reset_done",   {31'd0, mdu_if.done}, 32'd0);
    check("reset_result", mdu_if.result, 32'd0);
    check("reset_rd_out", {27'd0, mdu_if.rd_out}, 32'd0);
    check("reset_state",  {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Arithmetic vectors
    for (int i = 0; i < 20; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, lat, bcnt, de1);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_rd_out", i), {27'd0, rdo}, {27'd0, vecs[i].rd});
      check($sformatf("vec%0d_latency", i), lat, 32'd33);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 32'd33);
    end

    // Kill in RUN at count 10: result stays 25 / rd 9 from the last vector
    @(negedge clk);
    mdu_if.start = 1'b1; mdu_if.funct3 = 3'd0; mdu_if.a = 32'd100; mdu_if.b = 32'd100; mdu_if.rd_in = 5'd4;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("kill_run_state", {30'd0, dbg_state}, 32'd1);
    mdu_if.kill = 1'b1;
    @(posedge clk); #1;
    mdu_if.kill = 1'b0;
    check("kill_run_busy", {31'd0, mdu_if.busy}, 32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mdu_if.done) done_seen = 1'b1;
    end
    check("kill_run_no_done", {31'd0, done_seen}, 32'd0);
    check("kill_run_result",  mdu_if.result, 32'd25);
    check("kill_run_rd_out",  {27'd0, mdu_if.rd_out}, 32'd9);

    // Kill while in DONE: completion is suppressed
    @(negedge clk);
    mdu_if.start = 1'b1; mdu_if.funct3 = 3'd0; mdu_if.a = 32'd100; mdu_if.b = 32'd100; mdu_if.rd_in = 5'd4;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("kill_done_state", {30'd0, dbg_state}, 32'd2);
    mdu_if.kill = 1'b1;
    @(posedge clk); #1;
    mdu_if.kill = 1'b0;
    check("kill_done_pulse", {31'd0, mdu_if.done}, 32'd0);
    check("kill_done_busy",  {31'd0, mdu_if.busy}, 32'd0);
    check("kill_done_result", mdu_if.result, 32'd25);

    // Start while busy is dropped; first op's operands are used
    @(negedge clk);
    mdu_if.start = 1'b1; mdu_if.funct3 = 3'd5; mdu_if.a = 32'd100; mdu_if.b = 32'd7; mdu_if.rd_in = 5'd3;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    mdu_if.start = 1'b1; mdu_if.funct3 = 3'd0; mdu_if.a = 32'd1000; mdu_if.b = 32'd10; mdu_if.rd_in = 5'd7;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    lat = -1;
    for (int i = 7; i <= 60 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (mdu_if.done) begin
        lat = i; res = mdu_if.result; rdo = mdu_if.rd_out;
      end
    end
    check("busy_start_latency", lat, 32'd33);
    check("busy_start_result",  res, 32'd14);
    check("busy_start_rd_out",  {27'd0, rdo}, 32'd3);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mdu_if.done) done_seen = 1'b1;
    end
    check("busy_start_no_extra_done", {31'd0, done_seen}, 32'd0);

    // Back-to-back: second start asserted in the done cycle
    do_op(3'd0, 32'd2, 32'd3, 5'd1, res, rdo, lat, bcnt, de1);
    do_op(3'd0, 32'd4, 32'd5, 5'd2, res2, rdo2, lat, bcnt, de2);
    check("b2b_first_result",  res,  32'd6);
    check("b2b_second_result", res2, 32'd20);
    check("b2b_second_rd_out", {27'd0, rdo2}, 32'd2);
    check("b2b_done_spacing",  de2 - de1, 32'd34);

    // Asynchronous reset at RUN count 20
    @(negedge clk);
    mdu_if.start = 1'b1; mdu_if.funct3 = 3'd0; mdu_if.a = 32'hFFFF; mdu_if.b = 32'hFFFF; mdu_if.rd_in = 5'd11;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy",   {31'd0, mdu_if.busy}, 32'd0);
    check("async_rst_done",   {31'd0, mdu_if.done}, 32'd0);
    check("async_rst_result", mdu_if.result, 32'd0);
    check("async_rst_rd_out", {27'd0, mdu_if.rd_out}, 32'd0);
    check("async_rst_state",  {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(3'd0, 32'd3, 32'd3, 5'd12, res, rdo, lat, bcnt, de1);
    check("post_rst_result",  res, 32'd9);
    check("post_rst_rd_out",  {27'd0, rdo}, 32'd12);
    check("post_rst_latency", lat, 32'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_mdu.md
# riscv_mdu

Iterative RV32M multiply/divide unit sitting directly downstream of the register file read ports and upstream of its write port. It takes the two source operands (rd1/rd2), the M-extension funct3 and the destination register index, and computes the result over a fixed number of cycles. It returns the result with its destination index so the writeback path can drive the register file write port (we3/wa3/wd3).

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- REGW, 5, register index width.

- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- funct3  in  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  XLEN  rs1 operand (rd1).
- b  in  XLEN  rs2 operand (rd2).
- rd_in  in  REGW  destination register index.
- kill  in  1  synchronous abort (pipeline flush).
- busy  out  1  operation in progress; high from the cycle after acceptance through the DONE cycle.
- done  out  1  one-cycle pulse; result and rd_out valid.
- result  out  XLEN  operation result.
- rd_out  out  REGW  destination index of the result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and kill=0 latch funct3, rd_in and the operand magnitudes, plus sign flags per operation.
  - Signed operands: MULH a,b; MULHSU a only; DIV/REM a,b.
  - Counter is cleared to 0 and the state moves to RUN.
  - start with kill=1 is ignored.
- RUN performs one iteration per cycle for 32 cycles (counter 0..31), then goes to DONE.
  - Multiply: shift-add on unsigned magnitudes into a 64-bit product.
  - Divide: restoring, one quotient bit per cycle, 32-bit remainder plus carry bit.
- DONE:
  - Sign correction is applied.
    - Product is negated if the sign flags differ (MULH/MULHSU).
    - Quotient is negated if sign(a)≠sign(b).
    - Remainder takes the sign of a.
  - Result selection:
    - MUL takes product[31:0].
    - MULH/MULHSU/MULHU take product[63:32].
    - DIV/DIVU take the quotient.
    - REM/REMU take the remainder.
  - result and rd_out are registered, done=1, and the state returns to IDLE.
- Special cases, resolved in DONE with the same latency as normal operations:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return a unchanged.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- rd_in=0 is computed normally and reported with rd_out=0. Dropping the write is the register file's job, not this block's.
- kill=1 in RUN or DONE returns the state to IDLE on the next edge.
  - done is forced to 0 that cycle.
  - result and rd_out keep their previous values.
- start while busy=1 is ignored. No queueing.

## Timing
- Reset values (asserted asynchronously): state IDLE, busy=0, done=0, result=0, rd_out=0, counter=0.
- start accepted at edge E0:
  - busy=1 from after E0 through the DONE cycle.
  - done=1 for exactly the one cycle after edge E33.
  - Latency is 33 cycles for every funct3.
- busy is derived from state (state≠IDLE). done is registered.
- result and rd_out change only on the edge entering DONE. They hold until the next completed operation.
- Back-to-back: busy=0 in the cycle after DONE. A start there is accepted; there is no dead cycle beyond that.
- kill and reset_n both asserted: reset dominates.
- reset_n deassertion is assumed synchronised externally. The first start may be accepted on the first edge after deassertion.

## Test plan
- MUL a=7, b=6, rd_in=5, start at E0 -> done only in the cycle after E33, result=42, rd_out=5, busy high for 33 cycles.
- MULH a=0xFFFFFFFF (−1), b=0xFFFFFFFF -> result=0. MULHU same operands -> 0xFFFFFFFE. MULHSU a=−1, b=2 -> 0xFFFFFFFF.
- DIV a=−7, b=2 -> −3 (0xFFFFFFFD). REM same operands -> −1 (0xFFFFFFFF). DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- Divide by zero: DIV a=123, b=0 -> 0xFFFFFFFF. REM a=123, b=0 -> 123. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Protocol:
  - kill pulsed at RUN count 10 -> no done ever, busy low next cycle, result unchanged.
  - start while busy -> ignored; operands of the first op are used.
  - Back-to-back start in the cycle after done -> second done 34 cycles after the first.
- Reset mid-operation: reset_n low at RUN count 20 -> busy, done, result and rd_out go to 0 immediately without waiting for a clock edge. After release, a fresh MUL 3×3 -> 9.
